// File: rtl/fixed_to_float_pkg.sv
// Shared IEEE-754 single-precision field widths, result type and packing helper
// for the fixed-point to float conversion pipeline.
package fixed_to_float_pkg;

   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;
   localparam int FP32_BIAS  = 127;

   typedef struct packed {
      logic                  sign;
      logic [FP32_EXP_W-1:0] exp;
      logic [FP32_MAN_W-1:0] man;
   } fp32_t;

   function automatic fp32_t pack_fp32(input logic                  sign,
                                       input logic [FP32_EXP_W-1:0] exp,
                                       input logic [FP32_MAN_W-1:0] man);
      fp32_t f;
      f.sign = sign;
      f.exp  = exp;
      f.man  = man;
      return f;
   endfunction

endpackage

// File: rtl/leading_one_detect.sv
// Combinational priority encoder: index of the most significant set bit,
// plus a flag for an all-zero input.
module leading_one_detect #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]         value,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic                     zero
);

   localparam int PW = $clog2(WIDTH);

   // Ascending scan so the highest set bit is the last one to win.
   always_comb begin
      pos  = '0;
      zero = (value == '0);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) pos = PW'(i);
      end
   end

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Three-stage fixed-point to IEEE-754 single converter with valid/ready on both
// sides: S1 sign/magnitude, S2 normalise, S3 round and pack.
module fixed_to_float_pipe
   import fixed_to_float_pkg::*;
#(
   parameter int TOTAL_BITS      = 16,
   parameter int FRACTIONAL_BITS = 10,
   parameter int SIGNED_IN       = 1,
   parameter int ROUND_NEAREST   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [TOTAL_BITS-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_float,
   output logic                  out_inexact
);

   localparam int PW   = $clog2(TOTAL_BITS);
   localparam int PADW = TOTAL_BITS + FP32_MAN_W + 1;

   logic v1, v2, v3;
   logic load1, load2, load3;

   logic                  s1_sign;
   logic [TOTAL_BITS-1:0] s1_mag;
   logic                  s2_sign;
   logic                  s2_zero;
   logic [PW-1:0]         s2_pos;
   logic [TOTAL_BITS-2:0] s2_frac;

   logic                  in_sign;
   logic [TOTAL_BITS-1:0] in_mag;
   logic [PW-1:0]         lod_pos;
   logic                  lod_zero;
   logic [PW-1:0]         norm_shift;
   logic [TOTAL_BITS-2:0] frac_shifted;

   logic [PADW-1:0]       padded;
   logic [FP32_MAN_W-1:0] man_raw;
   logic                  guard;
   logic                  sticky;
   logic                  round_up;
   logic [FP32_MAN_W:0]   man_sum;
   logic signed [9:0]     exp_s;
   fp32_t                 s3_result;
   logic                  s3_inexact;

   // Each stage may advance when it is empty or the stage after it is moving.
   assign load3     = !v3 || out_ready;
   assign load2     = !v2 || load3;
   assign load1     = !v1 || load2;
   assign in_ready  = load1;
   assign out_valid = v3;

   // Negation is done at full width so the most-negative input becomes 2^(W-1).
   always_comb begin
      in_sign = (SIGNED_IN != 0) && in_data[TOTAL_BITS-1];
      in_mag  = in_sign ? -in_data : in_data;
   end

   leading_one_detect #(
      .WIDTH(TOTAL_BITS)
   ) u_lod (
      .value(s1_mag),
      .pos  (lod_pos),
      .zero (lod_zero)
   );

   // Only the bits below the leading one are kept; the hidden one is implicit.
   assign norm_shift   = PW'(TOTAL_BITS - 1) - lod_pos;
   assign frac_shifted = s1_mag[TOTAL_BITS-2:0] << norm_shift;

   // Zero padding below the fraction makes the p <= 23 case fall out exactly.
   always_comb begin
      padded     = {s2_frac, 25'b0};
      man_raw    = padded[PADW-1 -: FP32_MAN_W];
      guard      = padded[TOTAL_BITS];
      sticky     = |padded[TOTAL_BITS-1:0];
      round_up   = (ROUND_NEAREST != 0) && guard && (sticky || man_raw[0]);
      man_sum    = {1'b0, man_raw} + (FP32_MAN_W+1)'(round_up);
      exp_s      = 10'(s2_pos) - 10'(FRACTIONAL_BITS) + 10'(FP32_BIAS) + 10'(man_sum[FP32_MAN_W]);
      s3_result  = pack_fp32(s2_sign, exp_s[7:0], man_sum[FP32_MAN_W-1:0]);
      s3_inexact = guard || sticky;
      if (s2_zero) begin
         s3_result  = '0;
         s3_inexact = 1'b0;
      end
   end

   // Control and output registers are reset; in-flight samples are simply dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         v3          <= 1'b0;
         out_float   <= '0;
         out_inexact <= 1'b0;
      end else begin
         if (load1) v1 <= in_valid;
         if (load2) v2 <= v1;
         if (load3) begin
            v3 <= v2;
            if (v2) begin
               out_float   <= s3_result;
               out_inexact <= s3_inexact;
            end
         end
      end
   end

   // Datapath registers of empty stages are don't-care, so they carry no reset.
   always_ff @(posedge clk) begin
      if (load1 && in_valid) begin
         s1_sign <= in_sign;
         s1_mag  <= in_mag;
      end
      if (load2 && v1) begin
         s2_sign <= s1_sign;
         s2_zero <= lod_zero;
         s2_pos  <= lod_pos;
         s2_frac <= frac_shifted;
      end
   end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Drives four converter configurations in lockstep and checks them against an
// arithmetic reference model of the fixed-to-float conversion.
module tb_fixed_to_float_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [15:0] d16;
   logic [31:0] d32;
   logic [3:0]  rdy;
   logic [3:0]  vld;
   logic [3:0]  inx;
   logic [31:0] flt [4];

   int total;
   int bad;

   fixed_to_float_pipe #(.TOTAL_BITS(16), .FRACTIONAL_BITS(10), .SIGNED_IN(1), .ROUND_NEAREST(1)) dut_q510 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(d16),
      .out_valid(vld[0]), .out_ready(out_ready), .out_float(flt[0]), .out_inexact(inx[0]));

   fixed_to_float_pipe #(.TOTAL_BITS(16), .FRACTIONAL_BITS(10), .SIGNED_IN(0), .ROUND_NEAREST(1)) dut_u510 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(d16),
      .out_valid(vld[1]), .out_ready(out_ready), .out_float(flt[1]), .out_inexact(inx[1]));

   fixed_to_float_pipe #(.TOTAL_BITS(32), .FRACTIONAL_BITS(0), .SIGNED_IN(1), .ROUND_NEAREST(1)) dut_i32rn (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(d32),
      .out_valid(vld[2]), .out_ready(out_ready), .out_float(flt[2]), .out_inexact(inx[2]));

   fixed_to_float_pipe #(.TOTAL_BITS(32), .FRACTIONAL_BITS(0), .SIGNED_IN(1), .ROUND_NEAREST(0)) dut_i32tr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(d32),
      .out_valid(vld[3]), .out_ready(out_ready), .out_float(flt[3]), .out_inexact(inx[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exact value is mag * 2^-f; keep 24 significant bits and round on the remainder.
   function automatic logic [32:0] ref_fp(input logic [63:0] raw_in, input int w, input int f,
                                          input bit sgn, input bit rn);
      logic [63:0] wmask, raw, mag, kept, rem, half;
      logic [7:0]  e;
      int          p;
      int          sh;
      bit          neg;
      bit          inexact;
      wmask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      raw   = raw_in & wmask;
      neg   = sgn && raw[w-1];
      mag   = neg ? ((~raw + 64'd1) & wmask) : raw;
      if (mag == 64'd0) return 33'd0;
      p = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      inexact = 1'b0;
      if (p <= 23) begin
         kept = mag << (23 - p);
      end else begin
         sh      = p - 23;
         kept    = mag >> sh;
         rem     = mag & ((64'd1 << sh) - 64'd1);
         half    = 64'd1 << (sh - 1);
         inexact = (rem != 64'd0);
         if (rn && (rem > half || (rem == half && kept[0]))) kept = kept + 64'd1;
         if (kept[24]) begin
            kept = kept >> 1;
            p    = p + 1;
         end
      end
      e = 8'(p - f + 127);
      return {inexact, neg, e, kept[22:0]};
   endfunction

   function automatic logic [32:0] expect_dut(input int k, input logic [15:0] a, input logic [31:0] b);
      case (k)
         0:       return ref_fp({48'd0, a}, 16, 10, 1'b1, 1'b1);
         1:       return ref_fp({48'd0, a}, 16, 10, 1'b0, 1'b1);
         2:       return ref_fp({32'd0, b}, 32, 0, 1'b1, 1'b1);
         default: return ref_fp({32'd0, b}, 32, 0, 1'b1, 1'b0);
      endcase
   endfunction

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 9))
         0:       return 16'h8000;
         1:       return 16'h0000;
         2:       return 16'hFFFF;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 9))
         0:       return 32'h8000_0000;
         1:       return 32'h0000_0000;
         2:       return 32'h01FF_FFFF;
         3:       return 32'h0100_0001 | (32'($urandom_range(0, 1)) << 1);
         default: return 32'($urandom) >> $urandom_range(0, 31);
      endcase
   endfunction

   // Outputs must be cleared while reset is held.
   task automatic test_reset();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (vld[k] !== 1'b0 || flt[k] !== 32'h0 || inx[k] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state dut%0d: got v=%b f=%h x=%b want v=0 f=0 x=0", k, vld[k], flt[k], inx[k]);
         end
      end
   endtask

   // Four back-to-back samples, results exactly 3..6 cycles after the first accept.
   task automatic test_back_to_back();
      logic [15:0] vin  [4];
      logic [31:0] vout [4];
      vin  = '{16'h0400, 16'hFC00, 16'h0000, 16'h0001};
      vout = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h3A80_0000};
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         in_valid  = (c < 4);
         out_ready = 1'b1;
         if (c < 4) d16 = vin[c];
         @(negedge clk);
         total++;
         if (rdy[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_ready cycle %0d: got %b want 1", c, rdy[0]);
         end
         total++;
         if (c >= 3 && c <= 6) begin
            if (vld[0] !== 1'b1 || flt[0] !== vout[c-3] || inx[0] !== 1'b0) begin
               bad++;
               $display("[TB] FAIL b2b_result cycle %0d: got v=%b f=%h x=%b want v=1 f=%h x=0",
                        c, vld[0], flt[0], inx[0], vout[c-3]);
            end
         end else if (vld[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_latency cycle %0d: got out_valid=%b want 0", c, vld[0]);
         end
      end
   endtask

   // Most-negative input, unsigned reading, and the 32-bit rounding corners.
   task automatic test_corners();
      logic [31:0] vin  [3];
      logic [31:0] vrn  [3];
      vin = '{32'h0100_0001, 32'h0100_0003, 32'h01FF_FFFF};
      vrn = '{32'h4B80_0000, 32'h4B80_0002, 32'h4C00_0000};
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         in_valid  = (c < 3);
         out_ready = 1'b1;
         d16       = 16'h8000;
         if (c < 3) d32 = vin[c];
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            total++;
            if (vld[0] !== 1'b1 || flt[0] !== 32'hC200_0000 || flt[1] !== 32'h4200_0000 || inx[0] !== 1'b0 || inx[1] !== 1'b0) begin
               bad++;
               $display("[TB] FAIL most_negative cycle %0d: got v=%b s=%h u=%h want v=1 s=c2000000 u=42000000", c, vld[0], flt[0], flt[1]);
            end
            total++;
            if (flt[2] !== vrn[c-3] || inx[2] !== 1'b1) begin
               bad++;
               $display("[TB] FAIL round_nearest cycle %0d: got f=%h x=%b want f=%h x=1", c, flt[2], inx[2], vrn[c-3]);
            end
         end
         if (c == 5) begin
            total++;
            if (flt[3] !== 32'h4BFF_FFFF || inx[3] !== 1'b1) begin
               bad++;
               $display("[TB] FAIL truncate: got f=%h x=%b want f=4bffffff x=1", flt[3], inx[3]);
            end
         end
      end
   endtask

   // Eight distinct samples with out_ready in a 1-high/2-low pattern and input gaps.
   task automatic test_backpressure();
      logic [47:0] q[$];
      logic [47:0] e;
      logic [32:0] x;
      logic [31:0] prev_flt;
      bit          prev_stall;
      bit          exp_rdy;
      int          sent;
      int          got;
      sent = 0; got = 0; prev_stall = 1'b0; prev_flt = '0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         @(posedge clk); #1;
         in_valid  = (sent < 8) && ($urandom_range(0, 9) < 8);
         d16       = 16'(16'h1111 * (sent + 1));
         d32       = pick32();
         out_ready = (cyc % 3 == 0);
         @(negedge clk);
         total++;
         exp_rdy = !(q.size() == 3 && !out_ready);
         if (rdy[0] !== exp_rdy) begin
            bad++;
            $display("[TB] FAIL bp_in_ready cycle %0d: got %b want %b (held=%0d)", cyc, rdy[0], exp_rdy, q.size());
         end
         if (prev_stall) begin
            total++;
            if (vld[0] !== 1'b1 || flt[0] !== prev_flt) begin
               bad++;
               $display("[TB] FAIL bp_stall_hold cycle %0d: got v=%b f=%h want v=1 f=%h", cyc, vld[0], flt[0], prev_flt);
            end
         end
         prev_stall = vld[0] && !out_ready;
         prev_flt   = flt[0];
         if (vld[0] && out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("[TB] FAIL bp_extra_output: got f=%h want no output", flt[0]);
            end else begin
               e = q.pop_front();
               for (int k = 0; k < 4; k++) begin
                  x = expect_dut(k, e[15:0], e[47:16]);
                  if (k > 0) total++;
                  if ({inx[k], flt[k]} !== x) begin
                     bad++;
                     $display("[TB] FAIL bp_result dut%0d #%0d: got %h want %h", k, got, {inx[k], flt[k]}, x);
                  end
               end
            end
            got++;
         end
         if (in_valid && rdy[0]) begin
            q.push_back({d32, d16});
            sent++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total++;
      if (got != 8 || q.size() != 0) begin
         bad++;
         $display("[TB] FAIL bp_count: got %0d outputs (%0d pending) want 8 (0 pending)", got, q.size());
      end
   endtask

   // Random data with random valid/ready on both sides, all four configurations checked.
   task automatic test_random(input int n);
      logic [47:0] q[$];
      logic [47:0] e;
      logic [32:0] x;
      int          sent;
      int          got;
      sent = 0; got = 0;
      for (int cyc = 0; cyc < n * 10 && got < n; cyc++) begin
         @(posedge clk); #1;
         in_valid  = (sent < n) && ($urandom_range(0, 9) < 7);
         d16       = pick16();
         d32       = pick32();
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (vld[0] && out_ready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL rand_extra_output: got f=%h want no output", flt[0]);
            end else begin
               e = q.pop_front();
               for (int k = 0; k < 4; k++) begin
                  x = expect_dut(k, e[15:0], e[47:16]);
                  total++;
                  if ({inx[k], flt[k]} !== x) begin
                     bad++;
                     $display("[TB] FAIL rand_result dut%0d in=%h/%h: got %h want %h", k, e[15:0], e[47:16], {inx[k], flt[k]}, x);
                  end
               end
            end
            got++;
         end
         if (in_valid && rdy[0]) begin
            q.push_back({d32, d16});
            sent++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total++;
      if (got != n) begin
         bad++;
         $display("[TB] FAIL rand_count: got %0d outputs want %0d", got, n);
      end
   endtask

   // Reset with three samples held, then a single fresh sample must appear 3 cycles later.
   task automatic test_reset_midstream();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         in_valid  = 1'b1;
         out_ready = 1'b0;
         d16       = 16'h0400;
         d32       = 32'h0000_0005;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2;
      total++;
      if (vld[0] !== 1'b1 || flt[0] !== 32'h3F80_0000) begin
         bad++;
         $display("[TB] FAIL pre_reset_full: got v=%b f=%h want v=1 f=3f800000", vld[0], flt[0]);
      end
      rst = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (vld[k] !== 1'b0 || flt[k] !== 32'h0 || inx[k] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset dut%0d: got v=%b f=%h x=%b want v=0 f=0 x=0", k, vld[k], flt[k], inx[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         in_valid  = (c == 0);
         out_ready = 1'b1;
         d16       = 16'hFC00;
         @(negedge clk);
         total++;
         if (c == 3) begin
            if (vld[0] !== 1'b1 || flt[0] !== 32'hBF80_0000) begin
               bad++;
               $display("[TB] FAIL post_reset_result: got v=%b f=%h want v=1 f=bf800000", vld[0], flt[0]);
            end
         end else if (vld[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_stale cycle %0d: got out_valid=%b want 0", c, vld[0]);
         end
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d16       = '0;
      d32       = '0;
      repeat (3) @(posedge clk);
      test_reset();
      rst = 1'b0;
      test_back_to_back();
      test_corners();
      test_backpressure();
      test_random(300);
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
